// File: rtl/mem_burst_arbiter_pkg.sv
// Shared types and constants for the memory burst arbiter: FSM encoding,
// ring slot indices and default bus widths.
package mem_burst_arbiter_pkg;

    localparam int DEF_MEM_DATA_BITS = 64;
    localparam int DEF_ADDR_BITS     = 24;
    localparam int DEF_LEN_BITS      = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // Ring order W0, R0, W1, R1: bit 0 flags a reader, bit 1 is the requester index.
    localparam logic [1:0] SLOT_W0 = 2'd0;
    localparam logic [1:0] SLOT_R0 = 2'd1;
    localparam logic [1:0] SLOT_W1 = 2'd2;
    localparam logic [1:0] SLOT_R1 = 2'd3;

    function automatic logic [1:0] onehot_to_slot(input logic [3:0] oh);
        logic [1:0] slot;
        slot = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) slot = 2'(i);
        end
        return slot;
    endfunction

endpackage

// File: rtl/mem_burst_arbiter_if.sv
// Burst port pair towards mem_ctrl; master is the arbiter, slave the controller.
interface mem_burst_arbiter_if
    import mem_burst_arbiter_pkg::*;
#(
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int LEN_BITS      = DEF_LEN_BITS
);
    logic                     m_wr_burst_req;
    logic [LEN_BITS-1:0]      m_wr_burst_len;
    logic [ADDR_BITS-1:0]     m_wr_burst_addr;
    logic [MEM_DATA_BITS-1:0] m_wr_burst_data;
    logic                     m_wr_burst_data_req;
    logic                     m_wr_burst_finish;
    logic                     m_rd_burst_req;
    logic [LEN_BITS-1:0]      m_rd_burst_len;
    logic [ADDR_BITS-1:0]     m_rd_burst_addr;
    logic [MEM_DATA_BITS-1:0] m_rd_burst_data;
    logic                     m_rd_burst_data_valid;
    logic                     m_rd_burst_finish;

    modport master (
        output m_wr_burst_req, m_wr_burst_len, m_wr_burst_addr, m_wr_burst_data,
        output m_rd_burst_req, m_rd_burst_len, m_rd_burst_addr,
        input  m_wr_burst_data_req, m_wr_burst_finish,
        input  m_rd_burst_data, m_rd_burst_data_valid, m_rd_burst_finish
    );

    modport slave (
        input  m_wr_burst_req, m_wr_burst_len, m_wr_burst_addr, m_wr_burst_data,
        input  m_rd_burst_req, m_rd_burst_len, m_rd_burst_addr,
        output m_wr_burst_data_req, m_wr_burst_finish,
        output m_rd_burst_data, m_rd_burst_data_valid, m_rd_burst_finish
    );

endinterface

// File: rtl/mem_burst_arbiter_rr_pick4.sv
// Four-way round-robin pick: first requesting slot at or after ptr, one-hot out.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter sharing one mem_ctrl read/write burst port pair among two
// writers and two readers; exactly one burst is outstanding at any time.
//
// state   | meaning
// IDLE    | waiting for calib_done and a request; grants on the next edge
// WR_BUSY | write burst owned by writer gslot[1]; strobes forwarded
// RD_BUSY | read burst owned by reader gslot[1]; strobes forwarded
// DONE    | one-cycle gap so the finished requester can drop its request
module mem_burst_arbiter
    import mem_burst_arbiter_pkg::*;
#(
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int LEN_BITS      = DEF_LEN_BITS
) (
    input  logic                       mem_clk,
    input  logic                       rst_n,
    input  logic                       calib_done,
    input  logic [1:0]                 wr_req,
    input  logic [2*LEN_BITS-1:0]      wr_len,
    input  logic [2*ADDR_BITS-1:0]     wr_addr,
    input  logic [2*MEM_DATA_BITS-1:0] wr_data,
    output logic [1:0]                 wr_data_req,
    output logic [1:0]                 wr_finish,
    input  logic [1:0]                 rd_req,
    input  logic [2*LEN_BITS-1:0]      rd_len,
    input  logic [2*ADDR_BITS-1:0]     rd_addr,
    output logic [MEM_DATA_BITS-1:0]   rd_data,
    output logic [1:0]                 rd_data_valid,
    output logic [1:0]                 rd_finish,
    mem_burst_arbiter_if.master        mem
);

    arb_state_t           state;
    logic [1:0]           ptr;
    logic [1:0]           gslot;
    logic [LEN_BITS-1:0]  len_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 zero_q;
    logic                 wr_req_q;
    logic                 rd_req_q;

    logic [3:0]           req_vec;
    logic [3:0]           gnt_oh;
    logic                 gnt_valid;
    logic [1:0]           pick;
    logic [LEN_BITS-1:0]  pick_len;
    logic [ADDR_BITS-1:0] pick_addr;

    always_comb begin
        req_vec          = '0;
        req_vec[SLOT_W0] = wr_req[0];
        req_vec[SLOT_R0] = rd_req[0];
        req_vec[SLOT_W1] = wr_req[1];
        req_vec[SLOT_R1] = rd_req[1];
    end

    rr_pick4 u_pick (
        .req   (req_vec),
        .ptr   (ptr),
        .gnt   (gnt_oh),
        .valid (gnt_valid)
    );

    assign pick = onehot_to_slot(gnt_oh);

    always_comb begin
        if (pick[0]) begin
            pick_len  = pick[1] ? rd_len[2*LEN_BITS-1:LEN_BITS]    : rd_len[LEN_BITS-1:0];
            pick_addr = pick[1] ? rd_addr[2*ADDR_BITS-1:ADDR_BITS] : rd_addr[ADDR_BITS-1:0];
        end else begin
            pick_len  = pick[1] ? wr_len[2*LEN_BITS-1:LEN_BITS]    : wr_len[LEN_BITS-1:0];
            pick_addr = pick[1] ? wr_addr[2*ADDR_BITS-1:ADDR_BITS] : wr_addr[ADDR_BITS-1:0];
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= SLOT_W0;
            gslot    <= SLOT_W0;
            len_q    <= '0;
            addr_q   <= '0;
            zero_q   <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (calib_done && gnt_valid) begin
                        gslot  <= pick;
                        ptr    <= pick + 2'd1;
                        len_q  <= pick_len;
                        addr_q <= pick_addr;
                        // Zero-length grants never reach the controller; finish from DONE.
                        if (pick_len == '0) begin
                            zero_q <= 1'b1;
                            state  <= DONE;
                        end else if (pick[0]) begin
                            rd_req_q <= 1'b1;
                            state    <= RD_BUSY;
                        end else begin
                            wr_req_q <= 1'b1;
                            state    <= WR_BUSY;
                        end
                    end
                end
                WR_BUSY: begin
                    if (mem.m_wr_burst_finish) begin
                        wr_req_q <= 1'b0;
                        state    <= DONE;
                    end
                end
                RD_BUSY: begin
                    if (mem.m_rd_burst_finish) begin
                        rd_req_q <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    zero_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_data_req   = '0;
        wr_finish     = '0;
        rd_data_valid = '0;
        rd_finish     = '0;
        if (state == WR_BUSY) begin
            wr_data_req[gslot[1]] = mem.m_wr_burst_data_req;
            wr_finish[gslot[1]]   = mem.m_wr_burst_finish;
        end
        if (state == RD_BUSY) begin
            rd_data_valid[gslot[1]] = mem.m_rd_burst_data_valid;
            rd_finish[gslot[1]]     = mem.m_rd_burst_finish;
        end
        if (state == DONE && zero_q) begin
            if (gslot[0]) rd_finish[gslot[1]] = 1'b1;
            else          wr_finish[gslot[1]] = 1'b1;
        end
    end

    assign mem.m_wr_burst_req  = wr_req_q;
    assign mem.m_wr_burst_len  = len_q;
    assign mem.m_wr_burst_addr = addr_q;
    assign mem.m_wr_burst_data = gslot[1] ? wr_data[2*MEM_DATA_BITS-1:MEM_DATA_BITS]
                                          : wr_data[MEM_DATA_BITS-1:0];
    assign mem.m_rd_burst_req  = rd_req_q;
    assign mem.m_rd_burst_len  = len_q;
    assign mem.m_rd_burst_addr = addr_q;
    assign rd_data             = mem.m_rd_burst_data;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter with a behavioural mem_ctrl model and a
// passive monitor that tallies strobes, grants and inter-burst gaps.
module tb_mem_burst_arbiter;

    localparam int MB = 64;
    localparam int AB = 24;
    localparam int LB = 10;

    logic            mem_clk;
    logic            rst_n;
    logic            calib_done;
    logic [1:0]      wr_req;
    logic [2*LB-1:0] wr_len;
    logic [2*AB-1:0] wr_addr;
    logic [2*MB-1:0] wr_data;
    logic [1:0]      wr_data_req;
    logic [1:0]      wr_finish;
    logic [1:0]      rd_req;
    logic [2*LB-1:0] rd_len;
    logic [2*AB-1:0] rd_addr;
    logic [MB-1:0]   rd_data;
    logic [1:0]      rd_data_valid;
    logic [1:0]      rd_finish;

    mem_burst_arbiter_if #(.MEM_DATA_BITS(MB), .ADDR_BITS(AB), .LEN_BITS(LB)) mem ();

    mem_burst_arbiter #(.MEM_DATA_BITS(MB), .ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .mem_clk       (mem_clk),
        .rst_n         (rst_n),
        .calib_done    (calib_done),
        .wr_req        (wr_req),
        .wr_len        (wr_len),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_data_req   (wr_data_req),
        .wr_finish     (wr_finish),
        .rd_req        (rd_req),
        .rd_len        (rd_len),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .rd_finish     (rd_finish),
        .mem           (mem)
    );

    int total = 0;
    int bad   = 0;

    initial begin
        mem_clk = 1'b0;
        forever #5 mem_clk = ~mem_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Controller model: sees the request at a negedge, issues len strobes, then finish.
    logic inj_wdreq, inj_wfin, inj_rvalid, inj_rfin;
    int   wcnt, rcnt, rbeat;
    bit   wact, ract;

    initial begin
        logic wdr, wfn, rvl, rfn;
        wact = 0; ract = 0; wcnt = 0; rcnt = 0; rbeat = 0;
        mem.m_wr_burst_data_req   = 1'b0;
        mem.m_wr_burst_finish     = 1'b0;
        mem.m_rd_burst_data_valid = 1'b0;
        mem.m_rd_burst_finish     = 1'b0;
        mem.m_rd_burst_data       = '0;
        forever begin
            @(negedge mem_clk);
            wdr = 0; wfn = 0; rvl = 0; rfn = 0;
            if (!rst_n) begin
                wact = 0;
                ract = 0;
            end else begin
                if (!wact && mem.m_wr_burst_req) begin wact = 1; wcnt = int'(mem.m_wr_burst_len); end
                if (wact) begin
                    if (wcnt > 0) begin wdr = 1; wcnt--; end
                    else begin wfn = 1; wact = 0; end
                end
                if (!ract && mem.m_rd_burst_req) begin ract = 1; rcnt = int'(mem.m_rd_burst_len); end
                if (ract) begin
                    if (rcnt > 0) begin rvl = 1; rcnt--; rbeat++; end
                    else begin rfn = 1; ract = 0; end
                end
            end
            mem.m_wr_burst_data_req   = wdr | inj_wdreq;
            mem.m_wr_burst_finish     = wfn | inj_wfin;
            mem.m_rd_burst_data_valid = rvl | inj_rvalid;
            mem.m_rd_burst_finish     = rfn | inj_rfin;
            mem.m_rd_burst_data       = rvl ? (64'hC0DE_0000_0000_0000 | 64'(rbeat)) : '0;
        end
    end

    // Monitor: samples 2 ns after each negedge, well clear of the posedge.
    int   cyc, last_fin, glog_n;
    int   n_wdreq [2];
    int   n_wfin  [2];
    int   n_rval  [2];
    int   n_rfin  [2];
    int   n_wdata_bad, n_rdata_bad, n_both, n_wrise, n_rrise;
    logic [AB-1:0] glog_addr [64];
    bit   glog_rd  [64];
    int   glog_gap [64];
    logic pw, pr;

    initial begin
        cyc = 0; last_fin = -100; glog_n = 0;
        n_wdata_bad = 0; n_rdata_bad = 0; n_both = 0; n_wrise = 0; n_rrise = 0;
        for (int g = 0; g < 2; g++) begin n_wdreq[g] = 0; n_wfin[g] = 0; n_rval[g] = 0; n_rfin[g] = 0; end
        pw = 0; pr = 0;
        forever begin
            @(negedge mem_clk);
            #2;
            cyc++;
            for (int g = 0; g < 2; g++) begin
                if (wr_data_req[g] === 1'b1) begin
                    n_wdreq[g]++;
                    if (mem.m_wr_burst_data !== wr_data[g*MB +: MB]) n_wdata_bad++;
                end
                if (wr_finish[g] === 1'b1) n_wfin[g]++;
                if (rd_data_valid[g] === 1'b1) begin
                    n_rval[g]++;
                    if (rd_data !== mem.m_rd_burst_data) n_rdata_bad++;
                end
                if (rd_finish[g] === 1'b1) n_rfin[g]++;
            end
            if (mem.m_wr_burst_req === 1'b1 && mem.m_rd_burst_req === 1'b1) n_both++;
            if (mem.m_wr_burst_req === 1'b1 && !pw && glog_n < 64) begin
                n_wrise++;
                glog_addr[glog_n] = mem.m_wr_burst_addr; glog_rd[glog_n] = 0;
                glog_gap[glog_n] = cyc - last_fin; glog_n++;
            end
            if (mem.m_rd_burst_req === 1'b1 && !pr && glog_n < 64) begin
                n_rrise++;
                glog_addr[glog_n] = mem.m_rd_burst_addr; glog_rd[glog_n] = 1;
                glog_gap[glog_n] = cyc - last_fin; glog_n++;
            end
            if ((wr_finish | rd_finish) != 2'b00) last_fin = cyc;
            pw = mem.m_wr_burst_req;
            pr = mem.m_rd_burst_req;
        end
    end

    task automatic wait_fin(input bit rd, input int idx, input int budget, output int took);
        took = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge mem_clk);
            #3;
            if ((rd ? rd_finish[idx] : wr_finish[idx]) === 1'b1) begin
                took = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({mem.m_wr_burst_req, mem.m_rd_burst_req, wr_data_req, wr_finish, rd_data_valid, rd_finish} !== 10'h0) begin
            bad++; $display("FAIL reset_held_outputs got=%0h exp=0",
                {mem.m_wr_burst_req, mem.m_rd_burst_req, wr_data_req, wr_finish, rd_data_valid, rd_finish});
        end
        @(negedge mem_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge mem_clk);
        #3;
        total++;
        if ({mem.m_wr_burst_len, mem.m_wr_burst_addr, mem.m_rd_burst_len, mem.m_rd_burst_addr} !== '0) begin
            bad++; $display("FAIL reset_len_addr got=%0h exp=0", {mem.m_wr_burst_len, mem.m_wr_burst_addr});
        end
        total++;
        if (dut.ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
        total++;
        if ({mem.m_wr_burst_req, mem.m_rd_burst_req} !== 2'b00) begin
            bad++; $display("FAIL reset_released_reqs got=%b exp=00", {mem.m_wr_burst_req, mem.m_rd_burst_req});
        end
    endtask

    task automatic test_calib_gate();
        int rise0, dr0, fin0, took;
        @(negedge mem_clk);
        rise0 = n_wrise; dr0 = n_wdreq[0]; fin0 = n_wfin[0];
        wr_len[LB-1:0] = 10'd5; wr_addr[AB-1:0] = 24'h00ABCD; wr_req = 2'b01;
        repeat (100) @(negedge mem_clk);
        #3;
        total++;
        if (n_wrise - rise0 !== 0 || mem.m_wr_burst_req !== 1'b0) begin
            bad++; $display("FAIL calib_low_grant rises=%0d exp=0", n_wrise - rise0);
        end
        @(negedge mem_clk);
        calib_done = 1'b1;
        @(negedge mem_clk);
        #3;
        total++;
        if ({mem.m_wr_burst_req, mem.m_wr_burst_len, mem.m_wr_burst_addr} !== {1'b1, 10'd5, 24'h00ABCD}) begin
            bad++; $display("FAIL calib_grant req=%b len=%0d addr=%0h exp req=1 len=5 addr=abcd",
                mem.m_wr_burst_req, mem.m_wr_burst_len, mem.m_wr_burst_addr);
        end
        wait_fin(0, 0, 40, took);
        wr_req = 2'b00;
        total++;
        if (took < 0) begin bad++; $display("FAIL calib_w0_finish timeout got=%0d exp=>0", took); end
        repeat (5) @(negedge mem_clk);
        #3;
        total++;
        if (n_wdreq[0] - dr0 !== 5 || n_wfin[0] - fin0 !== 1) begin
            bad++; $display("FAIL calib_w0_strobes dreq=%0d fin=%0d exp 5 1", n_wdreq[0] - dr0, n_wfin[0] - fin0);
        end
    endtask

    task automatic test_read_r0();
        int v0, v1, f0, f1, rb, rr, took;
        v0 = n_rval[0]; v1 = n_rval[1]; f0 = n_rfin[0]; f1 = n_rfin[1]; rb = n_rdata_bad; rr = n_rrise;
        rd_len[LB-1:0] = 10'd4; rd_addr[AB-1:0] = 24'h000200; rd_req = 2'b01;
        wait_fin(1, 0, 40, took);
        rd_req = 2'b00;
        total++;
        if (took < 0) begin bad++; $display("FAIL r0_finish timeout got=%0d exp=>0", took); end
        repeat (5) @(negedge mem_clk);
        #3;
        total++;
        if (n_rval[0] - v0 !== 4 || n_rval[1] - v1 !== 0) begin
            bad++; $display("FAIL r0_valid_count v0=%0d v1=%0d exp 4 0", n_rval[0] - v0, n_rval[1] - v1);
        end
        total++;
        if (n_rfin[0] - f0 !== 1 || n_rfin[1] - f1 !== 0) begin
            bad++; $display("FAIL r0_finish_count f0=%0d f1=%0d exp 1 0", n_rfin[0] - f0, n_rfin[1] - f1);
        end
        total++;
        if (n_rdata_bad - rb !== 0 || n_rrise - rr !== 1) begin
            bad++; $display("FAIL r0_data bad=%0d rises=%0d exp 0 1", n_rdata_bad - rb, n_rrise - rr);
        end
    endtask

    task automatic test_write_w1();
        int d0, d1, f0, f1, wb, took;
        d0 = n_wdreq[0]; d1 = n_wdreq[1]; f0 = n_wfin[0]; f1 = n_wfin[1]; wb = n_wdata_bad;
        wr_len[2*LB-1:LB] = 10'd8; wr_addr[2*AB-1:AB] = 24'h000100; wr_req = 2'b10;
        repeat (3) @(negedge mem_clk);
        #3;
        total++;
        if ({mem.m_wr_burst_req, mem.m_wr_burst_len, mem.m_wr_burst_addr} !== {1'b1, 10'd8, 24'h000100}) begin
            bad++; $display("FAIL w1_grant req=%b len=%0d addr=%0h exp 1 8 100",
                mem.m_wr_burst_req, mem.m_wr_burst_len, mem.m_wr_burst_addr);
        end
        calib_done = 1'b0;
        wait_fin(0, 1, 40, took);
        wr_req = 2'b00;
        total++;
        if (took < 0) begin bad++; $display("FAIL w1_finish_calib_low timeout got=%0d exp=>0", took); end
        calib_done = 1'b1;
        repeat (5) @(negedge mem_clk);
        #3;
        total++;
        if (n_wdreq[1] - d1 !== 8 || n_wdreq[0] - d0 !== 0) begin
            bad++; $display("FAIL w1_dreq d1=%0d d0=%0d exp 8 0", n_wdreq[1] - d1, n_wdreq[0] - d0);
        end
        total++;
        if (n_wfin[1] - f1 !== 1 || n_wfin[0] - f0 !== 0) begin
            bad++; $display("FAIL w1_finish f1=%0d f0=%0d exp 1 0", n_wfin[1] - f1, n_wfin[0] - f0);
        end
        total++;
        if (n_wdata_bad - wb !== 0) begin bad++; $display("FAIL w1_data bad_beats=%0d exp=0", n_wdata_bad - wb); end
    endtask

    task automatic test_zero_len();
        int rr, f1, took;
        rr = n_rrise; f1 = n_rfin[1];
        rd_len[2*LB-1:LB] = 10'd0; rd_addr[2*AB-1:AB] = 24'h000300; rd_req = 2'b10;
        wait_fin(1, 1, 3, took);
        rd_req = 2'b00;
        total++;
        if (took < 0) begin bad++; $display("FAIL zero_len_finish got=%0d exp=1..3", took); end
        repeat (5) @(negedge mem_clk);
        #3;
        total++;
        if (n_rrise - rr !== 0 || n_rfin[1] - f1 !== 1) begin
            bad++; $display("FAIL zero_len_counts rises=%0d fin=%0d exp 0 1", n_rrise - rr, n_rfin[1] - f1);
        end
    endtask

    task automatic test_idle_strobes();
        int gl;
        gl = glog_n;
        @(negedge mem_clk);
        inj_wdreq = 1; inj_wfin = 1; inj_rvalid = 1; inj_rfin = 1;
        repeat (2) @(negedge mem_clk);
        #3;
        total++;
        if ({wr_data_req, wr_finish, rd_data_valid, rd_finish} !== 8'h00) begin
            bad++; $display("FAIL idle_strobes got=%0h exp=0", {wr_data_req, wr_finish, rd_data_valid, rd_finish});
        end
        inj_wdreq = 0; inj_wfin = 0; inj_rvalid = 0; inj_rfin = 0;
        repeat (3) @(negedge mem_clk);
        #3;
        total++;
        if (glog_n - gl !== 0 || dut.ptr !== 2'd0) begin
            bad++; $display("FAIL idle_strobes_side_effect grants=%0d ptr=%0d exp 0 0", glog_n - gl, dut.ptr);
        end
    endtask

    task automatic test_back_to_back();
        logic [AB:0] exp [5];
        int base, both0;
        exp[0] = {1'b0, 24'h0A0000}; exp[1] = {1'b1, 24'h0B0000}; exp[2] = {1'b0, 24'h0C0000};
        exp[3] = {1'b1, 24'h0D0000}; exp[4] = {1'b0, 24'h0A0000};
        base = glog_n; both0 = n_both;
        wr_len = {10'd2, 10'd2}; rd_len = {10'd2, 10'd2};
        wr_addr = {24'h0C0000, 24'h0A0000}; rd_addr = {24'h0D0000, 24'h0B0000};
        wr_req = 2'b11; rd_req = 2'b11;
        for (int i = 0; i < 300 && glog_n < base + 5; i++) begin
            @(negedge mem_clk);
            #3;
        end
        wr_req = 2'b00; rd_req = 2'b00;
        total++;
        if (glog_n - base < 5) begin bad++; $display("FAIL rr_grant_count got=%0d exp=5", glog_n - base); end
        repeat (20) @(negedge mem_clk);
        #3;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({glog_rd[base+i], glog_addr[base+i]} !== exp[i]) begin
                bad++; $display("FAIL rr_order_%0d got=%0h exp=%0h", i, {glog_rd[base+i], glog_addr[base+i]}, exp[i]);
            end
        end
        for (int i = 1; i < 5; i++) begin
            total++;
            if (glog_gap[base+i] !== 3) begin
                bad++; $display("FAIL rr_gap_%0d got=%0d exp=3", i, glog_gap[base+i]);
            end
        end
        total++;
        if (n_both - both0 !== 0) begin bad++; $display("FAIL rr_both_reqs cycles=%0d exp=0", n_both - both0); end
    endtask

    task automatic test_reset_mid_write();
        int base;
        wr_len[2*LB-1:LB] = 10'd8; wr_addr[2*AB-1:AB] = 24'h000100; wr_req = 2'b10;
        repeat (4) @(negedge mem_clk);
        #3;
        total++;
        if (wr_data_req[1] !== 1'b1) begin bad++; $display("FAIL midwrite_active got=%b exp=1", wr_data_req[1]); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem.m_wr_burst_req, mem.m_rd_burst_req, wr_data_req, wr_finish, rd_data_valid, rd_finish,
             mem.m_wr_burst_len, mem.m_wr_burst_addr} !== '0) begin
            bad++; $display("FAIL async_reset_outputs req=%b dreq=%b len=%0d exp all 0",
                mem.m_wr_burst_req, wr_data_req, mem.m_wr_burst_len);
        end
        wr_len = {10'd3, 10'd3}; rd_len = {10'd3, 10'd3};
        wr_addr = {24'h0C0000, 24'h0A0000}; rd_addr = {24'h0D0000, 24'h0B0000};
        wr_req = 2'b11; rd_req = 2'b11;
        repeat (2) @(negedge mem_clk);
        base = glog_n;
        rst_n = 1'b1;
        #3;
        total++;
        if (dut.ptr !== 2'd0) begin bad++; $display("FAIL post_reset_ptr got=%0d exp=0", dut.ptr); end
        for (int i = 0; i < 20 && glog_n == base; i++) begin
            @(negedge mem_clk);
            #3;
        end
        wr_req = 2'b00; rd_req = 2'b00;
        total++;
        if (glog_n == base || {glog_rd[base], glog_addr[base]} !== {1'b0, 24'h0A0000}) begin
            bad++; $display("FAIL post_reset_first_grant got=%0h exp=0a0000", {glog_rd[base], glog_addr[base]});
        end
        repeat (15) @(negedge mem_clk);
    endtask

    initial begin
        rst_n = 1'b0; calib_done = 1'b0;
        wr_req = '0; rd_req = '0; wr_len = '0; rd_len = '0; wr_addr = '0; rd_addr = '0;
        wr_data = {64'h1111_2222_3333_4444, 64'h0A0A_0B0B_0C0C_0D0D};
        inj_wdreq = 0; inj_wfin = 0; inj_rvalid = 0; inj_rfin = 0;
        test_reset();
        test_calib_gate();
        test_read_r0();
        test_write_w1();
        test_zero_len();
        test_idle_strobes();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
